// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
package booth_pkg;

    localparam int BOOTH_WIDTH   = 16;
    localparam int BOOTH_NREQ    = 4;
    localparam int BOOTH_TIMEOUT = 48;

    // Index width that stays at least one bit wide for tiny counts.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int BOOTH_ID_W = id_width(BOOTH_NREQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_M,
        ST_LOAD_Q,
        ST_BUSY,
        ST_RESP
    } booth_arb_state_t;

endpackage

// File: rtl/booth_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Walk from the farthest candidate back to ptr so the nearest set bit wins last.
    always_comb begin
        int j;
        logic [IDW-1:0] jj;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDW'(j);
            if (req[jj]) begin
                any        = 1'b1;
                idx        = jj;
                onehot     = '0;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin arbiter that owns a shared Booth multiplier's operand bus and start.
module booth_arbiter
    import booth_pkg::*;
#(
    parameter int NREQ    = BOOTH_NREQ,
    parameter int WIDTH   = BOOTH_WIDTH,
    parameter int TIMEOUT = BOOTH_TIMEOUT,
    localparam int IDW    = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mcand,
    input  logic [NREQ*WIDTH-1:0] mplier,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      mul_data,
    output logic                  mul_start,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_result
);

    localparam int CW = id_width(TIMEOUT);

    booth_arb_state_t state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt;

    logic [NREQ-1:0]  sel_oh;
    logic [IDW-1:0]   sel_idx;
    logic             sel_any;
    logic [WIDTH-1:0] sel_mcand;
    logic [WIDTH-1:0] sel_mplier;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (sel_oh),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    assign sel_mcand  = mcand[sel_idx*WIDTH +: WIDTH];
    assign sel_mplier = mplier[sel_idx*WIDTH +: WIDTH];

    // Grant is the only combinational output; held low while reset is asserted.
    assign gnt = (rst && state == ST_IDLE) ? sel_oh : '0;

    // Arbitration FSM with registered multiplier drive, timeout and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            id_q      <= '0;
            mplier_q  <= '0;
            cnt       <= '0;
            mul_start <= 1'b0;
            mul_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        mul_start <= 1'b1;
                        mul_data  <= sel_mcand;
                        mplier_q  <= sel_mplier;
                        id_q      <= sel_idx;
                        ptr       <= (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                        state     <= ST_LOAD_M;
                    end
                end
                ST_LOAD_M: begin
                    mul_start <= 1'b0;
                    mul_data  <= mplier_q;
                    state     <= ST_LOAD_Q;
                end
                ST_LOAD_Q: begin
                    cnt   <= '0;
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_arbiter.sv
// Randomized scoreboard bench for booth_arbiter with a behavioural multiplier.
module tb_booth_arbiter;
    import booth_pkg::*;

    localparam int NREQ = BOOTH_NREQ;
    localparam int W    = BOOTH_WIDTH;
    localparam int TO   = BOOTH_TIMEOUT;
    localparam int IDW  = BOOTH_ID_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   mcand = '0;
    logic [NREQ*W-1:0]   mplier = '0;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_data;
    logic                rsp_err;
    logic [W-1:0]        mul_data;
    logic                mul_start;
    logic                mul_done = 1'b0;
    logic [2*W-1:0]      mul_result = '0;

    booth_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .mcand(mcand), .mplier(mplier),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_data(mul_data),
        .mul_start(mul_start), .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          err;
        int          gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mptr = 0;
    bit   busy = 0;
    bit   hang = 0;
    int   fixed_lat = 0;
    logic signed [W-1:0] opa [NREQ];
    logic signed [W-1:0] opb [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference arbitration: first requester at or after p, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            mcand[i*W +: W]  = opa[i];
            mplier[i*W +: W] = opb[i];
        end
    endtask

    // Grant monitor: compares gnt to the reference pick and queues the expected response.
    initial begin
        forever begin
            int s;
            int gi;
            logic [NREQ-1:0] expg;
            exp_t e;
            @(negedge clk);
            expg = '0;
            if (rst && !busy) begin
                s = rr_pick(req, mptr);
                if (s >= 0) expg[s] = 1'b1;
            end
            if (gnt != '0 || expg != '0) chk("gnt", 32'(gnt), 32'(expg));
            if (rst && gnt != '0) begin
                gi = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) gi = i;
                e.id   = gi;
                e.err  = hang;
                e.data = hang ? 32'd0 : 32'(opa[gi]) * 32'(opb[gi]);
                e.gcyc = cyc;
                exp_q.push_back(e);
                mptr = (gi + 1) % NREQ;
                busy = 1;
            end
        end
    end

    // Response monitor: pops on the first valid cycle, then checks stability until handshake.
    initial begin
        bit in_rsp;
        logic [31:0] hd;
        logic [31:0] hid;
        bit herr;
        exp_t e;
        int lt;
        in_rsp = 0;
        hd = '0;
        hid = '0;
        herr = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_rsp = 0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got id %0d data %0h, required none", rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.err) lt = 3 + TO;
                        else if (lat_q.size() != 0) lt = 3 + lat_q.pop_front();
                        else lt = -1;
                        chk("rsp_latency", 32'(cyc - e.gcyc), 32'(lt));
                    end
                    hd = rsp_data;
                    hid = 32'(rsp_id);
                    herr = rsp_err;
                end else begin
                    chk("rsp_hold_data", rsp_data, hd);
                    chk("rsp_hold_id", 32'(rsp_id), hid);
                    chk("rsp_hold_err", 32'(rsp_err), 32'(herr));
                end
                if (rsp_ready) begin
                    in_rsp = 0;
                    @(posedge clk);
                    busy = 0;
                end else begin
                    in_rsp = 1;
                end
            end
        end
    end

    // Behavioural multiplier: takes multiplicand with start, multiplier next cycle,
    // answers after a latency, and throws a stray done pulse that must be ignored.
    initial begin
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        int l;
        forever begin
            @(negedge clk);
            if (rst && mul_start) begin
                a = mul_data;
                @(negedge clk);
                b = mul_data;
                if (!hang) begin
                    l = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
                    lat_q.push_back(l);
                    if ($urandom_range(0, 1) == 1) begin
                        mul_done = 1'b1;
                        mul_result = 32'hDEAD_BEEF;
                    end
                    @(posedge clk);
                    #1;
                    mul_done = 1'b0;
                    repeat (l - 1) @(posedge clk);
                    #1;
                    mul_done = 1'b1;
                    mul_result = 32'(a) * 32'(b);
                    @(posedge clk);
                    #1;
                    mul_done = 1'b0;
                    mul_result = $urandom;
                end
            end
        end
    end

    // Drop each granted request until everything is drained and idle.
    task automatic serve(input int maxc);
        int n;
        logic [NREQ-1:0] g;
        n = 0;
        while ((req != '0 || busy || exp_q.size() != 0 || rsp_valid) && n < maxc) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            req = req & ~g;
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL serve_bound: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic op(input int id, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        @(posedge clk);
        #1;
        opa[id] = a;
        opb[id] = b;
        pack();
        req[id] = 1'b1;
        serve(300);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        chk({tag, "_mul_data"}, 32'(mul_data), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    endtask

    initial begin
        int n;
        int ng;
        logic [NREQ-1:0] g;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        pack();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b1;

        // single request with a fixed multiplier latency
        fixed_lat = 18;
        op(0, 16'sd7, -16'sd3);

        // timeout, then a normal operation afterwards
        fixed_lat = 5;
        hang = 1;
        op(3, 16'sd100, 16'sd200);
        hang = 0;
        op(1, -16'sd1234, 16'sd99);

        // operand extremes
        op(0, -16'sd32768, -16'sd32768);
        op(2, 16'sd32767, -16'sd32768);

        // backpressure: response held 10 cycles while another requester waits
        fixed_lat = 3;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        opa[2] = 16'sd321;
        opb[2] = -16'sd45;
        opa[1] = 16'sd11;
        opb[1] = 16'sd13;
        pack();
        req[2] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[2] && n < 100);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        req[1] = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        serve(300);

        // reset mid-BUSY: requester 2 in flight leaves ptr at 3; after reset 2 must win over 3
        hang = 1;
        @(posedge clk);
        #1;
        req[2] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[2] && n < 100);
        @(posedge clk);
        #1;
        req = 4'b1100;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        busy = 0;
        mptr = 0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check_zero_outputs("midreset");
        hang = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        serve(300);

        // round robin with every requester held high
        fixed_lat = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
        pack();
        req = '1;
        ng = 0;
        n = 0;
        while (ng < 5 && n < 400) begin
            @(negedge clk);
            if (gnt != '0) ng++;
            n++;
        end
        chk("rr_grant_count", 32'(ng), 32'd5);
        @(posedge clk);
        #1;
        req = '0;
        serve(300);

        // random traffic
        fixed_lat = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            req = req & ~g;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !g[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 5))
                        0: begin opa[i] = 16'h8000; opb[i] = 16'h7fff; end
                        1: begin opa[i] = 16'hffff; opb[i] = 16'h8000; end
                        default: begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
                    endcase
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            pack();
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        req = '0;
        rsp_ready = 1'b1;
        serve(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(10 * 60000);
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_arbiter.md
# booth_arbiter

Shares one 16-bit Booth multiplier datapath among `NREQ` requesters. Each requester presents a multiplicand/multiplier pair. The block picks one request round-robin and drives the multiplier's shared operand bus and start strobe: multiplicand first, then multiplier. It waits for done and returns the 32-bit signed product with the requester's ID. It sits between the client logic and the multiplier top level, and owns the multiplier's `data_in`/`start` inputs exclusively.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand width; product is `2*WIDTH`.
- `TIMEOUT`, 48: cycles allowed in BUSY before the error response.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `mcand`  in  NREQ*WIDTH  packed multiplicands; requester i at `[i*WIDTH +: WIDTH]`.
- `mplier`  in  NREQ*WIDTH  packed multipliers, same packing.
- `gnt`  out  NREQ  one-hot, one-cycle acknowledge; operands are captured in this cycle.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  clog2(NREQ)  requester index of the response.
- `rsp_data`  out  2*WIDTH  signed product.
- `rsp_err`  out  1  timeout; `rsp_data` is 0.
- `mul_data`  out  WIDTH  to multiplier `data_in`.
- `mul_start`  out  1  to multiplier `start`.
- `mul_done`  in  1  multiplier done.
- `mul_result`  in  2*WIDTH  multiplier `{A,Q}`.

## Operation
- The FSM has five states: IDLE, LOAD_M, LOAD_Q, BUSY, RESP.
- **IDLE:**
  - If any `req` bit is set, select the first set bit searching upward from `ptr`, with wrap-around.
  - Pulse `gnt[sel]` and latch `mcand`, `mplier` and the ID.
  - Set `ptr <= (sel+1) mod NREQ`, then go to LOAD_M.
- **LOAD_M:** `mul_start=1`, `mul_data=` latched multiplicand. Go to LOAD_Q.
- **LOAD_Q:** `mul_start=0`, `mul_data=` latched multiplier. Clear the timeout counter. Go to BUSY.
- **BUSY:**
  - `mul_data` holds the multiplier value.
  - On `mul_done`, latch `mul_result` into `rsp_data`, set `rsp_err=0`, go to RESP.
  - Otherwise, if the counter reaches `TIMEOUT-1`, set `rsp_data=0`, `rsp_err=1`, go to RESP.
- **RESP:**
  - `rsp_valid=1`; `rsp_id`, `rsp_data` and `rsp_err` are stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- **Requester rules:**
  - A requester may drop `req` at any time before `gnt`; a dropped request is never granted.
  - After `gnt`, the requester must re-assert `req` for a new operation.
  - `req` still high in the cycle after `gnt` counts as a new request.
- `mul_done` is ignored outside BUSY.
- No new grant is issued while the block is in LOAD_M, LOAD_Q, BUSY or RESP. One operation is in flight at a time.
- Arithmetic is two's complement. `rsp_data` is `mul_result` unmodified, with no sign re-extension.

## Timing
- Reset values:
  - State is IDLE and `ptr` is 0.
  - `gnt`, `rsp_valid`, `rsp_err`, `mul_start` are 0.
  - `mul_data`, `rsp_data`, `rsp_id` are 0.
  - The timeout counter is 0.
- Reset asserted mid-operation aborts the operation silently: no response is issued, and the multiplier is reinitialised by its next `mul_start`.
- Outputs are registered except `gnt`, which is decoded from IDLE and the selection.
- Latency from `gnt` cycle (cycle 0) to first `rsp_valid` cycle is 3 + D. D is the number of cycles from the LOAD_Q cycle to the first `mul_done` sample.
- `rsp_valid` stays high until handshaked. The next grant can occur in the cycle after the handshake.
- A timeout response is produced exactly `TIMEOUT` cycles after entering BUSY.

## Structure
- Package `booth_pkg`:
  - state enum `booth_arb_state_t`
  - `BOOTH_WIDTH=16`
  - default `NREQ`/`TIMEOUT` constants
  - `clog2`-based ID width
- Sub-module `rr_picker`: combinational first-set-bit search from `ptr`, producing a one-hot output, a binary index and an `any` flag.
- The FSM, operand latches, timeout counter and response register live in the top level.

## Test plan
- Single request: req0 with mcand=7, mplier=−3; model done after 18 cycles → `mul_data` sequence 7, −3; `rsp_id=0`, `rsp_data=0xFFFF_FFEB`, `rsp_err=0`.
- Round-robin: req0..3 held high continuously → grants issued in order 0,1,2,3,0; no requester granted twice while others wait.
- Backpressure: `rsp_ready=0` for 10 cycles → `rsp_valid`/data stable for 10 cycles, no new `gnt`, grant in the cycle after the handshake.
- Timeout: `mul_done` never asserted → `rsp_err=1`, `rsp_data=0` at BUSY+48; the next request proceeds normally.
- Extremes: −32768 × −32768 → `0x4000_0000`; 32767 × −32768 → `0xC000_8000`.
- Reset mid-BUSY: deassert `rst` → all outputs 0 immediately, no `rsp_valid`; after release, req2 is granted first search from `ptr=0`.
